reset_seq: RTL
==============

Name: reset_seq

Overview:
- Staged reset sequencer directly downstream of the global reset synchronizer/BUFG stage; consumes its buffered active-low reset.
- Releases per-domain resets in a fixed order: memory subsystem, then peripherals, then the core. A programmable gap separates each release, and the periph release waits for memory-init completion.
- Also turns software and watchdog reset requests into a timed, full re-sequence, and reports the reset cause.

Parameters:
- STAGE_DELAY, 16, clock edges between consecutive stage releases; legal range ≥1.
- INIT_TIMEOUT, 1024, max edges spent waiting for mem_init_done_i before proceeding anyway; legal range ≥1.
- SW_RST_HOLD, 32, edges all outputs stay asserted after a sw/wdt request; legal range ≥1.
- Elaboration-time check: any parameter <1 is an error.
- CNT_W (localparam) = $clog2(max(STAGE_DELAY, INIT_TIMEOUT, SW_RST_HOLD)+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low (the buffered global reset).
- sw_rst_req_i  in  1  software reset request, level-sampled.
- wdt_rst_req_i  in  1  watchdog reset request, level-sampled.
- mem_init_done_i  in  1  memory init complete, level.
- rst_n_mem_o  out  1  memory-domain reset, active-low.
- rst_n_periph_o  out  1  peripheral-domain reset, active-low.
- rst_n_core_o  out  1  core reset, active-low.
- rst_cause_o  out  2  00 = POR/ext, 01 = SW, 10 = WDT, 11 unused.
- init_timeout_o  out  1  sticky flag: init wait timed out.
- busy_o  out  1  1 while any stage reset is asserted.

Behaviour:
- All outputs are registers, updated on the same edge as the FSM transition that changes them; there is no combinational path from inputs to outputs.
- rst_n=0 (sampled at posedge): FSM=HOLD, cnt=0, all three rst_n_*_o=0, rst_cause_o=00, init_timeout_o=0, busy_o=1. This overrides everything, mid-sequence included.
- Counted-wait rule: a wait state entered at edge E with cnt=0 transitions at edge E+N (N = its parameter); cnt resets to 0 on every state change.
- HOLD (N=STAGE_DELAY) -> MEM_INIT; rst_n_mem_o<=1 on that edge. Edge 0 is the last edge sampling rst_n=0, so mem releases at edge STAGE_DELAY.
- MEM_INIT: mem_init_done_i is sampled every edge.
  - Sampled 1 -> PERIPH_WAIT.
  - If cnt reaches INIT_TIMEOUT-1 without done -> PERIPH_WAIT and init_timeout_o<=1.
  - Done and timeout on the same edge: done wins, no flag.
  - A done level already high on entry counts on the first MEM_INIT edge.
- PERIPH_WAIT (N=STAGE_DELAY) -> CORE_WAIT; rst_n_periph_o<=1.
- CORE_WAIT (N=STAGE_DELAY) -> RUN; rst_n_core_o<=1, busy_o<=0.
- RUN: on an edge sampling wdt_rst_req_i=1 or sw_rst_req_i=1 -> ASSERT.
  - All three rst_n_*_o<=0 and busy_o<=1 on that same edge.
  - rst_cause_o<=10 if wdt_rst_req_i is set (wdt wins when both are set), else 01.
- ASSERT (N=SW_RST_HOLD) -> HOLD, then the normal sequence.
  - rst_cause_o and init_timeout_o are NOT cleared; init_timeout_o is cleared only by rst_n.
  - A request still high when RUN is re-entered triggers again.
- Requests in any state other than RUN are ignored, not queued.
- Deassertion order is strictly mem -> periph -> core; assertion is simultaneous.
- No output glitches; each output changes at most once per transition.

Test Plan:
- POR, STAGE_DELAY=4, mem_init_done_i tied 1, rst_n high after edge 0 -> mem rises at edge 4, periph at 9, core at 13; busy_o falls at 13; rst_cause_o=00.
- Same setup, done rises at edge 20 -> periph at edge 25 (sampled at 21, +4); core at 29; init_timeout_o=0.
- INIT_TIMEOUT=8, done held 0 -> MEM_INIT entered at 4, timeout at 12, periph at 16, core at 20; init_timeout_o=1 and sticky through a later sw reset.
- In RUN, sw_rst_req_i pulses 1 cycle sampled at edge R, SW_RST_HOLD=6 -> all outputs 0 at R; mem at R+10, periph at R+15, core at R+19; rst_cause_o=01.
- sw and wdt set together in RUN -> rst_cause_o=10. A wdt pulse during CORE_WAIT is ignored and the core still releases on schedule.
- rst_n driven 0 for 1 cycle mid PERIPH_WAIT -> all outputs 0 on that edge, rst_cause_o=00, init_timeout_o=0; full sequence restarts from HOLD.

Source files
------------

// File: rtl/reset_seq.sv
// ============================================================================
//  Module   : reset_seq
//  Purpose  : Staged reset sequencer. Releases memory, peripheral and core
//             resets in order with programmable gaps, waits (bounded) for
//             memory init, and turns sw/wdt requests into a full re-sequence.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_seq #(
    parameter int STAGE_DELAY  = 16,
    parameter int INIT_TIMEOUT = 1024,
    parameter int SW_RST_HOLD  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req_i,
    input  logic       wdt_rst_req_i,
    input  logic       mem_init_done_i,
    output logic       rst_n_mem_o,
    output logic       rst_n_periph_o,
    output logic       rst_n_core_o,
    output logic [1:0] rst_cause_o,
    output logic       init_timeout_o,
    output logic       busy_o
);

    localparam int c_MAX_AB = (STAGE_DELAY > INIT_TIMEOUT) ? STAGE_DELAY : INIT_TIMEOUT;
    localparam int c_MAX_N  = (c_MAX_AB > SW_RST_HOLD) ? c_MAX_AB : SW_RST_HOLD;
    localparam int CNT_W    = $clog2(c_MAX_N + 1);

    // A wait of N edges leaves its state on the edge that samples cnt == N-1.
    localparam logic [CNT_W-1:0] c_STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] c_INIT_LAST  = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(SW_RST_HOLD - 1);

    localparam logic [1:0] c_CAUSE_SW  = 2'b01;
    localparam logic [1:0] c_CAUSE_WDT = 2'b10;

    generate
        if (STAGE_DELAY < 1 || INIT_TIMEOUT < 1 || SW_RST_HOLD < 1) begin : g_param_check
            $error("reset_seq: STAGE_DELAY, INIT_TIMEOUT and SW_RST_HOLD must all be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_HOLD        = 3'd0,
        S_MEM_INIT    = 3'd1,
        S_PERIPH_WAIT = 3'd2,
        S_CORE_WAIT   = 3'd3,
        S_RUN         = 3'd4,
        S_ASSERT      = 3'd5
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_rst_n_mem, w_rst_n_mem;
    logic             r_rst_n_periph, w_rst_n_periph;
    logic             r_rst_n_core, w_rst_n_core;
    logic [1:0]       r_cause, w_cause;
    logic             r_init_timeout, w_init_timeout;
    logic             r_busy, w_busy;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Next-state and next-output logic; every output change rides on a state change.
    always_comb begin
        w_state        = r_state;
        w_cnt          = r_cnt;
        w_rst_n_mem    = r_rst_n_mem;
        w_rst_n_periph = r_rst_n_periph;
        w_rst_n_core   = r_rst_n_core;
        w_cause        = r_cause;
        w_init_timeout = r_init_timeout;
        w_busy         = r_busy;

        case (r_state)
            S_HOLD: begin
                if (r_cnt == c_STAGE_LAST) begin
                    w_state     = S_MEM_INIT;
                    w_cnt       = '0;
                    w_rst_n_mem = 1'b1;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_MEM_INIT: begin
                // Done takes priority over the timeout on the same edge.
                if (mem_init_done_i) begin
                    w_state = S_PERIPH_WAIT;
                    w_cnt   = '0;
                end else if (r_cnt == c_INIT_LAST) begin
                    w_state        = S_PERIPH_WAIT;
                    w_cnt          = '0;
                    w_init_timeout = 1'b1;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_PERIPH_WAIT: begin
                if (r_cnt == c_STAGE_LAST) begin
                    w_state        = S_CORE_WAIT;
                    w_cnt          = '0;
                    w_rst_n_periph = 1'b1;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_CORE_WAIT: begin
                if (r_cnt == c_STAGE_LAST) begin
                    w_state      = S_RUN;
                    w_cnt        = '0;
                    w_rst_n_core = 1'b1;
                    w_busy       = 1'b0;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_RUN: begin
                if (wdt_rst_req_i || sw_rst_req_i) begin
                    w_state        = S_ASSERT;
                    w_cnt          = '0;
                    w_rst_n_mem    = 1'b0;
                    w_rst_n_periph = 1'b0;
                    w_rst_n_core   = 1'b0;
                    w_busy         = 1'b1;
                    w_cause        = wdt_rst_req_i ? c_CAUSE_WDT : c_CAUSE_SW;
                end
            end
            S_ASSERT: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state = S_HOLD;
                    w_cnt   = '0;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            default: begin
                // Unreachable encodings recover into a fully asserted hold.
                w_state        = S_HOLD;
                w_cnt          = '0;
                w_rst_n_mem    = 1'b0;
                w_rst_n_periph = 1'b0;
                w_rst_n_core   = 1'b0;
                w_busy         = 1'b1;
            end
        endcase
    end

    // State, counter and registered outputs; rst_n forces a full restart from HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_HOLD;
            r_cnt          <= '0;
            r_rst_n_mem    <= 1'b0;
            r_rst_n_periph <= 1'b0;
            r_rst_n_core   <= 1'b0;
            r_cause        <= 2'b00;
            r_init_timeout <= 1'b0;
            r_busy         <= 1'b1;
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_rst_n_mem    <= w_rst_n_mem;
            r_rst_n_periph <= w_rst_n_periph;
            r_rst_n_core   <= w_rst_n_core;
            r_cause        <= w_cause;
            r_init_timeout <= w_init_timeout;
            r_busy         <= w_busy;
        end
    end

    assign rst_n_mem_o    = r_rst_n_mem;
    assign rst_n_periph_o = r_rst_n_periph;
    assign rst_n_core_o   = r_rst_n_core;
    assign rst_cause_o    = r_cause;
    assign init_timeout_o = r_init_timeout;
    assign busy_o         = r_busy;

endmodule

`default_nettype wire
